mem_arb_rr: RTL and testbench
=============================

# mem_arb_rr

Parametrised N-port memory arbiter between the core's cache/TLB miss handlers (instruction side, data side, page walker, further requesters) and the shared line-wide memory port. It replaces the fixed two-input instruction/data arbiter. It adds:
- round-robin fairness;
- per-port outstanding-read credits;
- memory-side backpressure;
- tagged-response routing back to the requesting port.

Writes are posted: no response, no credit.

## Interface
Parameters:
- NUM_PORTS, 2, number of requesters; port 0 wins at reset.
- PA_WIDTH, 32, physical address width.
- LINE_WIDTH, 128, cache line width.
- MAX_OUTSTANDING, 4, in-flight reads per port; power of 2, ≥2.
- PORT_BITS, max(1,$clog2(NUM_PORTS)), derived.
- SEQ_BITS, $clog2(MAX_OUTSTANDING), derived.
- ID_WIDTH, PORT_BITS+SEQ_BITS, derived; id = {port, seq}, port in MSBs.

Ports:
- clk  in  1  clock; single clock domain, everything on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req_valid  in  NUM_PORTS  request valid per port.
- o_req_ready  out  NUM_PORTS  request accepted this cycle (valid && ready).
- i_req_addr  in  NUM_PORTS*PA_WIDTH  line address, port p at [p*PA_WIDTH +: PA_WIDTH].
- i_req_data  in  NUM_PORTS*LINE_WIDTH  store line.
- i_req_write  in  NUM_PORTS  1 = write, 0 = read.
- o_mem_enable  out  1  memory request valid.
- i_mem_ready  in  1  memory accepts the request this cycle.
- o_mem_addr  out  PA_WIDTH  request address.
- o_mem_data  out  LINE_WIDTH  request data.
- o_mem_write  out  1  request is a write.
- o_mem_id  out  ID_WIDTH  request tag.
- i_mem_valid  in  1  read response valid.
- i_mem_id  in  ID_WIDTH  response tag.
- i_mem_data  in  LINE_WIDTH  response line.
- o_resp_valid  out  NUM_PORTS  one-cycle response pulse to the owning port.
- o_resp_data  out  LINE_WIDTH  response line, shared by all ports.
- o_resp_id  out  ID_WIDTH  response tag.
- o_err_spurious  out  1  one-cycle pulse: response dropped.

## Operation
- Eligibility: port p is eligible when i_req_valid[p] and it is a write or credits[p] > 0.
- Output stage: a single registered stage holds the memory request. It is free when !o_mem_enable || i_mem_ready.
- Grant: when the output stage is free, grant the first eligible port scanning from rr_ptr upward and wrapping modulo NUM_PORTS. o_req_ready is one-hot or zero. It is combinational from current state and inputs only and never depends on i_mem_valid.
- On acceptance of port g:
  - load addr, data and write into the output stage;
  - o_mem_id = {g, seq[g]};
  - rr_ptr <= (g+1) mod NUM_PORTS;
  - for a read only: seq[g] <= seq[g]+1 (wraps modulo MAX_OUTSTANDING) and credits[g] decrements.
- Free output stage, no grant: o_mem_enable <= 0.
- Output stage not free: hold all o_mem_* stable, no grant.
- Response routing: p = i_mem_id[ID_WIDTH-1 -: PORT_BITS].
  - If p < NUM_PORTS and credits[p] < MAX_OUTSTANDING: pulse o_resp_valid[p], register i_mem_data and i_mem_id, credits[p] increments.
  - Otherwise drop the response and pulse o_err_spurious; no credit change.
- Same port issues a read and retires a response in one cycle: credits unchanged.
- Credits bound in-flight reads, so tags in flight per port are unique. Responses may return out of order.

## Timing
- Reset values:
  - o_mem_enable = 0; o_mem_addr, o_mem_data, o_mem_write, o_mem_id = 0;
  - o_resp_valid = 0, o_resp_data = 0, o_resp_id = 0, o_err_spurious = 0;
  - rr_ptr = 0, all seq = 0, all credits = MAX_OUTSTANDING.
  - o_req_ready is combinational and is 0 while rst is high.
- Request latency: acceptance at edge t; o_mem_enable high in cycle t+1.
- Throughput: one request per cycle while i_mem_ready = 1.
- Response latency: i_mem_valid at edge t; o_resp_valid[p] high for exactly cycle t+1. The credit is usable for a grant in cycle t+1.
- Backpressure: while o_mem_enable && !i_mem_ready, outputs are frozen and o_req_ready = 0.
- Reset mid-operation: clears all state. Responses arriving afterwards for pre-reset tags see credits full and are dropped with o_err_spurious.

## Test plan
- Reset, then ports 0 and 1 both request reads continuously with i_mem_ready = 1 -> grants alternate 0,1,0,1; o_mem_id sequence 0x0,0x4,0x1,0x5 (defaults).
- Port 0 issues 4 reads with no responses -> fifth read stalls (o_req_ready[0] = 0). A port-0 write is still accepted. Response id 0x2 -> o_resp_valid[0] next cycle, then the fifth read is granted.
- Hold i_mem_ready = 0 for 3 cycles with a request pending -> o_mem_addr, o_mem_data and o_mem_id stable; no grants; the request completes on the cycle i_mem_ready returns.
- Response id 0x1 arrives with credits[0] = 4, or with the port field ≥ NUM_PORTS (NUM_PORTS = 3) -> o_err_spurious pulses; no o_resp_valid; credits unchanged.
- Port 1 with 1 credit left issues a read in the same cycle its response returns -> credits[1] stays 1; o_resp_valid[1] pulses.
- Assert rst with 2 reads in flight, then deliver their responses -> both dropped with o_err_spurious; o_mem_enable = 0 after reset.

Source files
------------

// File: rtl/mem_arb_rr_if.sv
// Request/memory/response bundle between the miss handlers, mem_arb_rr and the shared memory port.
// The slave side is the arbiter; the master side drives requests and memory responses.
interface mem_arb_rr_if #(
    parameter int NUM_PORTS       = 2,
    parameter int PA_WIDTH        = 32,
    parameter int LINE_WIDTH      = 128,
    parameter int MAX_OUTSTANDING = 4
);
    localparam int PORT_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int SEQ_BITS  = $clog2(MAX_OUTSTANDING);
    localparam int ID_WIDTH  = PORT_BITS + SEQ_BITS;

    logic [NUM_PORTS-1:0]            i_req_valid;
    logic [NUM_PORTS-1:0]            o_req_ready;
    logic [NUM_PORTS*PA_WIDTH-1:0]   i_req_addr;
    logic [NUM_PORTS*LINE_WIDTH-1:0] i_req_data;
    logic [NUM_PORTS-1:0]            i_req_write;

    logic                            o_mem_enable;
    logic                            i_mem_ready;
    logic [PA_WIDTH-1:0]             o_mem_addr;
    logic [LINE_WIDTH-1:0]           o_mem_data;
    logic                            o_mem_write;
    logic [ID_WIDTH-1:0]             o_mem_id;

    logic                            i_mem_valid;
    logic [ID_WIDTH-1:0]             i_mem_id;
    logic [LINE_WIDTH-1:0]           i_mem_data;

    logic [NUM_PORTS-1:0]            o_resp_valid;
    logic [LINE_WIDTH-1:0]           o_resp_data;
    logic [ID_WIDTH-1:0]             o_resp_id;
    logic                            o_err_spurious;

    modport slave (
        input  i_req_valid, i_req_addr, i_req_data, i_req_write,
        input  i_mem_ready, i_mem_valid, i_mem_id, i_mem_data,
        output o_req_ready,
        output o_mem_enable, o_mem_addr, o_mem_data, o_mem_write, o_mem_id,
        output o_resp_valid, o_resp_data, o_resp_id, o_err_spurious
    );

    modport master (
        output i_req_valid, i_req_addr, i_req_data, i_req_write,
        output i_mem_ready, i_mem_valid, i_mem_id, i_mem_data,
        input  o_req_ready,
        input  o_mem_enable, o_mem_addr, o_mem_data, o_mem_write, o_mem_id,
        input  o_resp_valid, o_resp_data, o_resp_id, o_err_spurious
    );
endinterface

// File: rtl/mem_arb_rr.sv
// Round-robin N-port memory arbiter with per-port read credits and tagged response routing; request seen on memory 1 cycle after grant, response 1 cycle after return.
// A stalled memory port freezes the output stage and withholds all grants; ports out of read credits are skipped.
module mem_arb_rr #(
    parameter int NUM_PORTS       = 2,
    parameter int PA_WIDTH        = 32,
    parameter int LINE_WIDTH      = 128,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    mem_arb_rr_if.slave bus
);
    localparam int PORT_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int SEQ_BITS  = $clog2(MAX_OUTSTANDING);
    localparam int ID_WIDTH  = PORT_BITS + SEQ_BITS;
    localparam int CRED_BITS = SEQ_BITS + 1;
    localparam logic [CRED_BITS-1:0] CRED_FULL = CRED_BITS'(MAX_OUTSTANDING);

    logic [PORT_BITS-1:0]  rr_ptr_q, rr_ptr_d;
    logic [SEQ_BITS-1:0]   seq_q     [NUM_PORTS];
    logic [SEQ_BITS-1:0]   seq_d     [NUM_PORTS];
    logic [CRED_BITS-1:0]  credits_q [NUM_PORTS];
    logic [CRED_BITS-1:0]  credits_d [NUM_PORTS];

    logic                  mem_en_q, mem_en_d;
    logic [PA_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [LINE_WIDTH-1:0] mem_data_q, mem_data_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [ID_WIDTH-1:0]   mem_id_q, mem_id_d;

    logic [NUM_PORTS-1:0]  resp_vld_q, resp_vld_d;
    logic [LINE_WIDTH-1:0] resp_data_q, resp_data_d;
    logic [ID_WIDTH-1:0]   resp_id_q, resp_id_d;
    logic                  err_q, err_d;

    logic [NUM_PORTS-1:0]  elig;
    logic                  gnt_vld;
    logic [PORT_BITS-1:0]  gnt_idx;
    logic                  stage_free;
    logic                  accept;
    logic [NUM_PORTS-1:0]  gnt_oh;
    logic [PA_WIDTH-1:0]   sel_addr;
    logic [LINE_WIDTH-1:0] sel_data;
    logic                  sel_wr;
    logic [SEQ_BITS-1:0]   sel_seq;
    logic [PORT_BITS-1:0]  resp_port;
    logic [NUM_PORTS-1:0]  resp_hit;

    assign stage_free = !mem_en_q || bus.i_mem_ready;
    assign accept     = gnt_vld && stage_free && !rst;
    assign resp_port  = bus.i_mem_id[ID_WIDTH-1 -: PORT_BITS];

    // Writes are posted, so they never wait on a read credit.
    always_comb begin
        elig = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            elig[p] = bus.i_req_valid[p] && (bus.i_req_write[p] || (credits_q[p] != '0));
        end
    end

    // Two passes: ports at or above rr_ptr first, then the wrapped-around ones.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!gnt_vld && elig[p] && (p >= int'(rr_ptr_q))) begin
                gnt_vld = 1'b1;
                gnt_idx = PORT_BITS'(p);
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!gnt_vld && elig[p] && (p < int'(rr_ptr_q))) begin
                gnt_vld = 1'b1;
                gnt_idx = PORT_BITS'(p);
            end
        end
    end

    always_comb begin
        gnt_oh   = '0;
        sel_addr = '0;
        sel_data = '0;
        sel_wr   = 1'b0;
        sel_seq  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt_idx == PORT_BITS'(p)) begin
                gnt_oh[p] = accept;
                sel_addr  = bus.i_req_addr[p*PA_WIDTH +: PA_WIDTH];
                sel_data  = bus.i_req_data[p*LINE_WIDTH +: LINE_WIDTH];
                sel_wr    = bus.i_req_write[p];
                sel_seq   = seq_q[p];
            end
        end
    end

    // A response only counts if its port exists and actually has a read outstanding.
    always_comb begin
        resp_hit = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            resp_hit[p] = bus.i_mem_valid && (resp_port == PORT_BITS'(p)) &&
                          (credits_q[p] != CRED_FULL);
        end
    end

    always_comb begin
        mem_en_d   = mem_en_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_wr_d   = mem_wr_q;
        mem_id_d   = mem_id_q;
        rr_ptr_d   = rr_ptr_q;
        seq_d      = seq_q;
        credits_d  = credits_q;

        if (stage_free) begin
            mem_en_d = accept;
        end
        if (accept) begin
            mem_addr_d = sel_addr;
            mem_data_d = sel_data;
            mem_wr_d   = sel_wr;
            mem_id_d   = {gnt_idx, sel_seq};
            rr_ptr_d   = (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
        end

        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt_oh[p] && !sel_wr) begin
                seq_d[p] = seq_q[p] + 1'b1;
            end
            credits_d[p] = credits_q[p]
                         + CRED_BITS'(resp_hit[p])
                         - CRED_BITS'(gnt_oh[p] && !sel_wr);
        end

        resp_vld_d  = resp_hit;
        resp_data_d = resp_data_q;
        resp_id_d   = resp_id_q;
        if (|resp_hit) begin
            resp_data_d = bus.i_mem_data;
            resp_id_d   = bus.i_mem_id;
        end
        err_d = bus.i_mem_valid && !(|resp_hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_wr_q    <= 1'b0;
            mem_id_q    <= '0;
            resp_vld_q  <= '0;
            resp_data_q <= '0;
            resp_id_q   <= '0;
            err_q       <= 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                seq_q[p]     <= '0;
                credits_q[p] <= CRED_FULL;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            mem_en_q    <= mem_en_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_wr_q    <= mem_wr_d;
            mem_id_q    <= mem_id_d;
            resp_vld_q  <= resp_vld_d;
            resp_data_q <= resp_data_d;
            resp_id_q   <= resp_id_d;
            err_q       <= err_d;
            for (int p = 0; p < NUM_PORTS; p++) begin
                seq_q[p]     <= seq_d[p];
                credits_q[p] <= credits_d[p];
            end
        end
    end

    assign bus.o_req_ready    = gnt_oh;
    assign bus.o_mem_enable   = mem_en_q;
    assign bus.o_mem_addr     = mem_addr_q;
    assign bus.o_mem_data     = mem_data_q;
    assign bus.o_mem_write    = mem_wr_q;
    assign bus.o_mem_id       = mem_id_q;
    assign bus.o_resp_valid   = resp_vld_q;
    assign bus.o_resp_data    = resp_data_q;
    assign bus.o_resp_id      = resp_id_q;
    assign bus.o_err_spurious = err_q;
endmodule

// File: tb/tb_mem_arb_rr.sv
// Directed vector bench for mem_arb_rr: a 2-port instance driven from a cycle table, plus
// hand-written reset and 3-port sequences.
module tb_mem_arb_rr;
    logic clk = 1'b0;
    logic rst;
    logic rst3;
    always #5 clk = ~clk;

    mem_arb_rr_if #(.NUM_PORTS(2), .PA_WIDTH(32), .LINE_WIDTH(128), .MAX_OUTSTANDING(4)) if2 ();
    mem_arb_rr_if #(.NUM_PORTS(3), .PA_WIDTH(32), .LINE_WIDTH(128), .MAX_OUTSTANDING(4)) if3 ();

    mem_arb_rr #(.NUM_PORTS(2), .PA_WIDTH(32), .LINE_WIDTH(128), .MAX_OUTSTANDING(4)) u_dut (
        .clk(clk), .rst(rst), .bus(if2)
    );
    mem_arb_rr #(.NUM_PORTS(3), .PA_WIDTH(32), .LINE_WIDTH(128), .MAX_OUTSTANDING(4)) u_dut3 (
        .clk(clk), .rst(rst3), .bus(if3)
    );

    typedef struct {
        logic [1:0] vld;
        logic [1:0] wr;
        logic       mrdy;
        logic       mvld;
        logic [2:0] mid;
        logic [1:0] e_rdy;
        logic       e_en;
        logic [2:0] e_id;
        logic       e_wr;
        logic [1:0] e_resp;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [31:0] addr_of(input int p);
        return 32'h1000_0000 + 32'(p) * 32'h40;
    endfunction

    function automatic logic [127:0] data_of(input int p);
        return {4{addr_of(p) ^ 32'h5A5A_5A5A}};
    endfunction

    function automatic logic [127:0] rdata_of(input logic [3:0] id);
        return {4{32'hD000_0000 | 32'(id)}};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] vld, input logic [1:0] wr, input logic mrdy,
                       input logic mvld, input logic [2:0] mid, input logic [1:0] e_rdy,
                       input logic e_en, input logic [2:0] e_id, input logic e_wr,
                       input logic [1:0] e_resp, input logic e_err);
        vec_t v;
        v.vld = vld; v.wr = wr; v.mrdy = mrdy; v.mvld = mvld; v.mid = mid;
        v.e_rdy = e_rdy; v.e_en = e_en; v.e_id = e_id; v.e_wr = e_wr;
        v.e_resp = e_resp; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Each row is one cycle: inputs driven, outputs expected during that cycle.
        // Round robin between two reading ports, then return all four responses.
        add(2'b11, 2'b00, 1, 0, 0, 2'b01, 0, 0, 0, 2'b00, 0);
        add(2'b11, 2'b00, 1, 0, 0, 2'b10, 1, 0, 0, 2'b00, 0);
        add(2'b11, 2'b00, 1, 0, 0, 2'b01, 1, 4, 0, 2'b00, 0);
        add(2'b11, 2'b00, 1, 0, 0, 2'b10, 1, 1, 0, 2'b00, 0);
        add(2'b00, 2'b00, 1, 0, 0, 2'b00, 1, 5, 0, 2'b00, 0);
        add(2'b00, 2'b00, 1, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0);
        add(2'b00, 2'b00, 1, 1, 0, 2'b00, 0, 0, 0, 2'b00, 0);
        add(2'b00, 2'b00, 1, 1, 4, 2'b00, 0, 0, 0, 2'b01, 0);
        add(2'b00, 2'b00, 1, 1, 1, 2'b00, 0, 0, 0, 2'b10, 0);
        add(2'b00, 2'b00, 1, 1, 5, 2'b00, 0, 0, 0, 2'b01, 0);
        add(2'b00, 2'b00, 1, 0, 0, 2'b00, 0, 0, 0, 2'b10, 0);
        // Response for port 0 while its credits are full: dropped.
        add(2'b00, 2'b00, 1, 1, 1, 2'b00, 0, 0, 0, 2'b00, 0);
        add(2'b00, 2'b00, 1, 0, 0, 2'b00, 0, 0, 0, 2'b00, 1);
        add(2'b00, 2'b00, 1, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0);
        // Port 0 exhausts its credits; a write still goes; a response frees one read.
        add(2'b01, 2'b00, 1, 0, 0, 2'b01, 0, 0, 0, 2'b00, 0);
        add(2'b01, 2'b00, 1, 0, 0, 2'b01, 1, 2, 0, 2'b00, 0);
        add(2'b01, 2'b00, 1, 0, 0, 2'b01, 1, 3, 0, 2'b00, 0);
        add(2'b01, 2'b00, 1, 0, 0, 2'b01, 1, 0, 0, 2'b00, 0);
        add(2'b01, 2'b00, 1, 0, 0, 2'b00, 1, 1, 0, 2'b00, 0);
        add(2'b01, 2'b01, 1, 0, 0, 2'b01, 0, 0, 0, 2'b00, 0);
        add(2'b01, 2'b00, 1, 1, 2, 2'b00, 1, 2, 1, 2'b00, 0);
        add(2'b01, 2'b00, 1, 0, 0, 2'b01, 0, 0, 0, 2'b01, 0);
        add(2'b00, 2'b00, 1, 0, 0, 2'b00, 1, 2, 0, 2'b00, 0);
        add(2'b00, 2'b00, 1, 1, 3, 2'b00, 0, 0, 0, 2'b00, 0);
        add(2'b00, 2'b00, 1, 1, 0, 2'b00, 0, 0, 0, 2'b01, 0);
        add(2'b00, 2'b00, 1, 1, 1, 2'b00, 0, 0, 0, 2'b01, 0);
        add(2'b00, 2'b00, 1, 1, 2, 2'b00, 0, 0, 0, 2'b01, 0);
        add(2'b00, 2'b00, 1, 0, 0, 2'b00, 0, 0, 0, 2'b01, 0);
        // Memory backpressure for three cycles holds the stage and all grants.
        add(2'b10, 2'b00, 1, 0, 0, 2'b10, 0, 0, 0, 2'b00, 0);
        add(2'b11, 2'b00, 0, 0, 0, 2'b00, 1, 6, 0, 2'b00, 0);
        add(2'b11, 2'b00, 0, 0, 0, 2'b00, 1, 6, 0, 2'b00, 0);
        add(2'b11, 2'b00, 0, 0, 0, 2'b00, 1, 6, 0, 2'b00, 0);
        add(2'b11, 2'b00, 1, 0, 0, 2'b01, 1, 6, 0, 2'b00, 0);
        add(2'b00, 2'b00, 1, 0, 0, 2'b00, 1, 3, 0, 2'b00, 0);
        add(2'b00, 2'b00, 1, 1, 6, 2'b00, 0, 0, 0, 2'b00, 0);
        add(2'b00, 2'b00, 1, 1, 3, 2'b00, 0, 0, 0, 2'b10, 0);
        add(2'b00, 2'b00, 1, 0, 0, 2'b00, 0, 0, 0, 2'b01, 0);
        // Port 1 down to one credit: issue and retire in the same cycle.
        add(2'b10, 2'b00, 1, 0, 0, 2'b10, 0, 0, 0, 2'b00, 0);
        add(2'b10, 2'b00, 1, 0, 0, 2'b10, 1, 7, 0, 2'b00, 0);
        add(2'b10, 2'b00, 1, 0, 0, 2'b10, 1, 4, 0, 2'b00, 0);
        add(2'b10, 2'b00, 1, 1, 7, 2'b10, 1, 5, 0, 2'b00, 0);
        add(2'b10, 2'b00, 1, 0, 0, 2'b10, 1, 6, 0, 2'b10, 0);
        add(2'b10, 2'b00, 1, 0, 0, 2'b00, 1, 7, 0, 2'b00, 0);
        add(2'b00, 2'b00, 1, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0);

        rst  = 1'b1;
        rst3 = 1'b1;
        if2.i_req_valid = 2'b11;
        if2.i_req_write = 2'b00;
        if2.i_req_addr  = {addr_of(1), addr_of(0)};
        if2.i_req_data  = {data_of(1), data_of(0)};
        if2.i_mem_ready = 1'b1;
        if2.i_mem_valid = 1'b0;
        if2.i_mem_id    = '0;
        if2.i_mem_data  = '0;
        if3.i_req_valid = '0;
        if3.i_req_write = '0;
        if3.i_req_addr  = {addr_of(2), addr_of(1), addr_of(0)};
        if3.i_req_data  = {data_of(2), data_of(1), data_of(0)};
        if3.i_mem_ready = 1'b1;
        if3.i_mem_valid = 1'b0;
        if3.i_mem_id    = '0;
        if3.i_mem_data  = '0;

        // Reset state, with requests pending so that ready must be suppressed.
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        chk("reset ready", if2.o_req_ready, 2'b00);
        chk("reset mem_enable", if2.o_mem_enable, 1'b0);
        chk("reset mem_addr", if2.o_mem_addr, 32'h0);
        chk("reset mem_data", if2.o_mem_data, 128'h0);
        chk("reset mem_write", if2.o_mem_write, 1'b0);
        chk("reset mem_id", if2.o_mem_id, 3'h0);
        chk("reset resp_valid", if2.o_resp_valid, 2'b00);
        chk("reset resp_data", if2.o_resp_data, 128'h0);
        chk("reset resp_id", if2.o_resp_id, 3'h0);
        chk("reset err", if2.o_err_spurious, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        if2.i_req_valid = 2'b00;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if2.i_req_valid = vecs[i].vld;
            if2.i_req_write = vecs[i].wr;
            if2.i_mem_ready = vecs[i].mrdy;
            if2.i_mem_valid = vecs[i].mvld;
            if2.i_mem_id    = vecs[i].mid;
            if2.i_mem_data  = rdata_of({1'b0, vecs[i].mid});
            #1;
            n_vec++;
            chk($sformatf("v%0d req_ready", i), if2.o_req_ready, vecs[i].e_rdy);
            chk($sformatf("v%0d mem_enable", i), if2.o_mem_enable, vecs[i].e_en);
            if (vecs[i].e_en) begin
                chk($sformatf("v%0d mem_id", i), if2.o_mem_id, vecs[i].e_id);
                chk($sformatf("v%0d mem_write", i), if2.o_mem_write, vecs[i].e_wr);
                chk($sformatf("v%0d mem_addr", i), if2.o_mem_addr, addr_of(int'(vecs[i].e_id[2])));
                chk($sformatf("v%0d mem_data", i), if2.o_mem_data, data_of(int'(vecs[i].e_id[2])));
            end
            chk($sformatf("v%0d resp_valid", i), if2.o_resp_valid, vecs[i].e_resp);
            chk($sformatf("v%0d err_spurious", i), if2.o_err_spurious, vecs[i].e_err);
            if (vecs[i].e_resp != 2'b00 && i > 0) begin
                chk($sformatf("v%0d resp_id", i), if2.o_resp_id, vecs[i-1].mid);
                chk($sformatf("v%0d resp_data", i), if2.o_resp_data, rdata_of({1'b0, vecs[i-1].mid}));
            end
        end

        // Reset with port-1 reads 4..7 in flight; late responses must be dropped.
        @(negedge clk);
        rst = 1'b1;
        if2.i_req_valid = 2'b00;
        if2.i_mem_valid = 1'b0;
        #1;
        n_vec++;
        chk("midrst ready", if2.o_req_ready, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        chk("midrst mem_enable", if2.o_mem_enable, 1'b0);
        chk("midrst resp_valid", if2.o_resp_valid, 2'b00);
        @(negedge clk);
        if2.i_mem_valid = 1'b1;
        if2.i_mem_id    = 3'h4;
        @(negedge clk);
        if2.i_mem_id    = 3'h5;
        #1;
        n_vec++;
        chk("stale4 err", if2.o_err_spurious, 1'b1);
        chk("stale4 resp_valid", if2.o_resp_valid, 2'b00);
        @(negedge clk);
        if2.i_mem_valid = 1'b0;
        if2.i_req_valid = 2'b11;
        #1;
        n_vec++;
        chk("stale5 err", if2.o_err_spurious, 1'b1);
        chk("stale5 resp_valid", if2.o_resp_valid, 2'b00);
        chk("postrst ready", if2.o_req_ready, 2'b01);
        @(negedge clk);
        if2.i_req_valid = 2'b00;
        #1;
        n_vec++;
        chk("postrst err", if2.o_err_spurious, 1'b0);
        chk("postrst mem_enable", if2.o_mem_enable, 1'b1);
        chk("postrst mem_id", if2.o_mem_id, 3'h0);

        // Three-port instance: port field out of range and a full-credit port both drop.
        @(negedge clk);
        rst3 = 1'b0;
        @(negedge clk);
        if3.i_mem_valid = 1'b1;
        if3.i_mem_id    = 4'hC;
        if3.i_mem_data  = rdata_of(4'hC);
        @(negedge clk);
        if3.i_mem_id    = 4'h9;
        if3.i_mem_data  = rdata_of(4'h9);
        #1;
        n_vec++;
        chk("p3 badport err", if3.o_err_spurious, 1'b1);
        chk("p3 badport resp_valid", if3.o_resp_valid, 3'b000);
        @(negedge clk);
        if3.i_mem_valid = 1'b0;
        if3.i_req_valid = 3'b100;
        #1;
        n_vec++;
        chk("p3 fullcred err", if3.o_err_spurious, 1'b1);
        chk("p3 fullcred resp_valid", if3.o_resp_valid, 3'b000);
        chk("p3 port2 ready", if3.o_req_ready, 3'b100);
        @(negedge clk);
        if3.i_req_valid = 3'b000;
        if3.i_mem_valid = 1'b1;
        if3.i_mem_id    = 4'h8;
        if3.i_mem_data  = rdata_of(4'h8);
        #1;
        n_vec++;
        chk("p3 read err", if3.o_err_spurious, 1'b0);
        chk("p3 read mem_enable", if3.o_mem_enable, 1'b1);
        chk("p3 read mem_id", if3.o_mem_id, 4'h8);
        chk("p3 read mem_addr", if3.o_mem_addr, addr_of(2));
        @(negedge clk);
        if3.i_mem_valid = 1'b0;
        #1;
        n_vec++;
        chk("p3 resp_valid", if3.o_resp_valid, 3'b100);
        chk("p3 resp_id", if3.o_resp_id, 4'h8);
        chk("p3 resp_data", if3.o_resp_data, rdata_of(4'h8));
        chk("p3 resp err", if3.o_err_spurious, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
